// File: rtl/bfloat_pkg.sv
// Shared bfloat16 types and constants for the add/sub alignment datapath.
package bfloat_pkg;

    localparam logic [15:0] BF_QNAN    = 16'h7FC0;
    localparam logic [7:0]  BF_EXP_MAX = 8'hFF;
    localparam int unsigned MAN_W      = 11;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    // Stage-1 register contents: classified, swapped operands.
    typedef struct packed {
        logic        res_sign;
        logic [7:0]  exp_l;
        logic        hid_l;
        logic [6:0]  frac_l;
        logic        hid_s;
        logic [6:0]  frac_s;
        logic [7:0]  diff;
        logic        eff_sub;
        logic        special;
        logic [15:0] spec_res;
    } s1_t;

    // Stage-2 register contents: exactly what leaves the block.
    typedef struct packed {
        logic             res_sign;
        logic [7:0]       exp_l;
        logic [MAN_W-1:0] man_l;
        logic [MAN_W-1:0] man_s;
        logic             eff_sub;
        logic             special;
        logic [15:0]      spec_res;
    } s2_t;

endpackage

// File: rtl/bfloat_align_shift.sv
// Right shifter that folds every bit shifted out into the result LSB (sticky).
module bfloat_align_shift
    import bfloat_pkg::*;
(
    input  logic [MAN_W-1:0] in,
    input  logic [7:0]       sh,
    output logic [MAN_W-1:0] out
);

    logic [MAN_W-1:0] shifted;
    logic [MAN_W-1:0] lost_mask;
    logic             lost;

    always_comb begin
        shifted   = in >> sh;
        lost_mask = (sh >= 8'(MAN_W)) ? '1 : ((MAN_W'(1) << sh) - MAN_W'(1));
        lost      = |(in & lost_mask);
        out       = {shifted[MAN_W-1:1], shifted[0] | lost};
    end

endmodule

// File: rtl/bfloat_align.sv
// bfloat16 add/sub alignment: stage 1 classifies and swaps, stage 2 shifts the
// smaller significand with sticky. Two-entry elastic pipeline, full throughput.
module bfloat_align
    import bfloat_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_sign,
    output logic [7:0]       exp_l,
    output logic [MAN_W-1:0] man_l,
    output logic [MAN_W-1:0] man_s,
    output logic             eff_sub,
    output logic             special,
    output logic [15:0]      spec_res
);

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic s1_valid_q, out_valid_q;
    logic s1_adv, s2_adv;

    assign s2_adv   = ~out_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // Operand b carries its effective sign from here on.
    bf16_t        op_a, op_b;
    logic         a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, eff_c, swap;
    logic [6:0]   frac_a, frac_b;
    logic [14:0]  mag_a, mag_b;

    always_comb begin
        op_a   = a;
        op_b   = {b[15] ^ op, b[14:0]};
        eff_c  = op_a.sign ^ op_b.sign;
        a_zero = (op_a.exp == 8'd0);
        b_zero = (op_b.exp == 8'd0);
        frac_a = a_zero ? 7'd0 : op_a.frac;
        frac_b = b_zero ? 7'd0 : op_b.frac;
        a_nan  = (op_a.exp == BF_EXP_MAX) && (op_a.frac != 7'd0);
        b_nan  = (op_b.exp == BF_EXP_MAX) && (op_b.frac != 7'd0);
        a_inf  = (op_a.exp == BF_EXP_MAX) && (op_a.frac == 7'd0);
        b_inf  = (op_b.exp == BF_EXP_MAX) && (op_b.frac == 7'd0);
        mag_a  = {op_a.exp, frac_a};
        mag_b  = {op_b.exp, frac_b};
        swap   = mag_b > mag_a;
    end

    always_comb begin
        s1_d         = '0;
        s1_d.eff_sub = eff_c;
        if (a_nan || b_nan || (a_inf && b_inf && eff_c)) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = BF_QNAN;
        end else if (a_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {op_a.sign, BF_EXP_MAX, 7'd0};
        end else if (b_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {op_b.sign, BF_EXP_MAX, 7'd0};
        end else if (a_zero && b_zero) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {op_a.sign & op_b.sign, 15'd0};
        end else if (eff_c && (mag_a == mag_b)) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = 16'h0000;
        end else if (swap) begin
            s1_d.res_sign = op_b.sign;
            s1_d.exp_l    = op_b.exp;
            s1_d.hid_l    = ~b_zero;
            s1_d.frac_l   = frac_b;
            s1_d.hid_s    = ~a_zero;
            s1_d.frac_s   = frac_a;
            s1_d.diff     = op_b.exp - op_a.exp;
        end else begin
            s1_d.res_sign = op_a.sign;
            s1_d.exp_l    = op_a.exp;
            s1_d.hid_l    = ~a_zero;
            s1_d.frac_l   = frac_a;
            s1_d.hid_s    = ~b_zero;
            s1_d.frac_s   = frac_b;
            s1_d.diff     = op_a.exp - op_b.exp;
        end
    end

    logic [MAN_W-1:0] man_s_sh;

    bfloat_align_shift u_shift (
        .in  ({s1_q.hid_s, s1_q.frac_s, 3'b000}),
        .sh  (s1_q.diff),
        .out (man_s_sh)
    );

    always_comb begin
        s2_d          = '0;
        s2_d.res_sign = s1_q.res_sign;
        s2_d.exp_l    = s1_q.exp_l;
        s2_d.man_l    = {s1_q.hid_l, s1_q.frac_l, 3'b000};
        s2_d.man_s    = man_s_sh;
        s2_d.eff_sub  = s1_q.eff_sub;
        s2_d.special  = s1_q.special;
        s2_d.spec_res = s1_q.spec_res;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_q <= s2_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign res_sign  = s2_q.res_sign;
    assign exp_l     = s2_q.exp_l;
    assign man_l     = s2_q.man_l;
    assign man_s     = s2_q.man_s;
    assign eff_sub   = s2_q.eff_sub;
    assign special   = s2_q.special;
    assign spec_res  = s2_q.spec_res;

endmodule

// File: tb/tb_bfloat_align.sv
// Bench for bfloat_align: random traffic scored against an arithmetic model,
// plus directed latency, special-value, backpressure and reset scenarios.
module tb_bfloat_align;

    typedef struct packed {
        logic        res_sign;
        logic [7:0]  exp_l;
        logic [10:0] man_l;
        logic [10:0] man_s;
        logic        eff_sub;
        logic        special;
        logic [15:0] spec_res;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        res_sign;
    logic [7:0]  exp_l;
    logic [10:0] man_l;
    logic [10:0] man_s;
    logic        eff_sub;
    logic        special;
    logic [15:0] spec_res;

    int   checks = 0;
    int   errors = 0;
    res_t q[$];
    int   stall_age = 0;
    bit   prev_stall = 1'b0;
    res_t prev_out;

    bfloat_align dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_sign  (res_sign),
        .exp_l     (exp_l),
        .man_l     (man_l),
        .man_s     (man_s),
        .eff_sub   (eff_sub),
        .special   (special),
        .spec_res  (spec_res)
    );

    always #5 clk = ~clk;

    // Reference: works on integer magnitudes and divides instead of shifting.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic sub_op);
        res_t r;
        int   ex, ey, fx, fy, mx, my, el, es, fl, fs, sig_l, sig_s, d, ms;
        logic sx, sy, eff, nx, ny, ix, iy;
        r   = '0;
        sx  = x[15];
        sy  = y[15] ^ sub_op;
        ex  = int'(x[14:7]);
        ey  = int'(y[14:7]);
        fx  = (ex == 0) ? 0 : int'(x[6:0]);
        fy  = (ey == 0) ? 0 : int'(y[6:0]);
        eff = sx ^ sy;
        nx  = (ex == 255) && (x[6:0] != 0);
        ny  = (ey == 255) && (y[6:0] != 0);
        ix  = (ex == 255) && (x[6:0] == 0);
        iy  = (ey == 255) && (y[6:0] == 0);
        mx  = ex * 128 + fx;
        my  = ey * 128 + fy;
        r.eff_sub = eff;
        if (nx || ny || (ix && iy && eff)) begin
            r.special = 1'b1; r.spec_res = 16'h7FC0;
        end else if (ix) begin
            r.special = 1'b1; r.spec_res = {sx, 15'h7F80};
        end else if (iy) begin
            r.special = 1'b1; r.spec_res = {sy, 15'h7F80};
        end else if (ex == 0 && ey == 0) begin
            r.special = 1'b1; r.spec_res = {sx & sy, 15'h0};
        end else if (eff && mx == my) begin
            r.special = 1'b1; r.spec_res = 16'h0000;
        end else begin
            if (my > mx) begin
                r.res_sign = sy; el = ey; fl = fy; es = ex; fs = fx;
            end else begin
                r.res_sign = sx; el = ex; fl = fx; es = ey; fs = fy;
            end
            sig_l = ((el == 0) ? 0 : 1024) + fl * 8;
            sig_s = ((es == 0) ? 0 : 1024) + fs * 8;
            d     = el - es;
            if (d >= 11) begin
                ms = (sig_s != 0) ? 1 : 0;
            end else begin
                ms = sig_s / (1 << d);
                if (sig_s % (1 << d) != 0) ms = ms | 1;
            end
            r.exp_l = 8'(el);
            r.man_l = 11'(sig_l);
            r.man_s = 11'(ms);
        end
        return r;
    endfunction

    function automatic res_t mk(input logic rs, input logic [7:0] e, input logic [10:0] ml,
                                input logic [10:0] ms, input logic es, input logic sp,
                                input logic [15:0] sr);
        return {rs, e, ml, ms, es, sp, sr};
    endfunction

    function automatic logic [15:0] rnd_op(input logic [15:0] o);
        logic [15:0] lst [8];
        logic [7:0]  e;
        lst = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h0001, 16'h3F80,
                16'hBF80};
        case ($urandom % 6)
            0: return lst[3'($urandom)];
            1: begin
                e = o[14:7] + 8'($urandom_range(0, 12)) - 8'd6;
                return {1'($urandom), e, 7'($urandom)};
            end
            2: return o ^ {1'($urandom), 15'h0};
            3: return {o[15:7], 7'($urandom)};
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    function automatic res_t dut_out();
        return {res_sign, exp_l, man_l, man_s, eff_sub, special, spec_res};
    endfunction

    // Scoreboard: push on accept, pop on delivery, hold-check while stalled.
    always @(negedge clk) begin
        res_t got, e;
        got = dut_out();
        if (!rst_n) begin
            prev_stall = 1'b0;
            stall_age  = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (got !== prev_out || !out_valid) begin
                    errors++;
                    $display("FAIL stall_hold: got %h valid %b, required %h valid 1",
                             got, out_valid, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                stall_age = 0;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out: got %h, required no output", got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL data: got %h, required %h", got, e);
                    end
                end
            end else if (q.size() > 0) begin
                stall_age++;
                if (stall_age == 200) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout: got no output in 200 cycles, required %0d pending",
                             q.size());
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, op));
            prev_stall = out_valid && !out_ready;
            prev_out   = got;
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic o);
        int n;
        @(posedge clk); #1;
        a = x; b = y; op = o; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] bp_a [3];
        logic [15:0] bp_b [3];
        int          acc, cnt, n;
        bit          took;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_data", 64'(dut_out()), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);

        // Pin the model with hand-computed results.
        chk("pin_sub", 64'(model(16'h4000, 16'h3F80, 1'b1)),
            64'(mk(1'b0, 8'h80, 11'h400, 11'h200, 1'b1, 1'b0, 16'h0)));
        chk("pin_swap", 64'(model(16'h3F80, 16'hC040, 1'b0)),
            64'(mk(1'b1, 8'h80, 11'h600, 11'h200, 1'b1, 1'b0, 16'h0)));
        chk("pin_sticky", 64'(model(16'h4B00, 16'h3F81, 1'b0)),
            64'(mk(1'b0, 8'h96, 11'h400, 11'h001, 1'b0, 1'b0, 16'h0)));
        chk("pin_inf_inf", 64'(model(16'h7F80, 16'h7F80, 1'b1)),
            64'(mk(1'b0, 8'h0, 11'h0, 11'h0, 1'b1, 1'b1, 16'h7FC0)));
        chk("pin_cancel", 64'(model(16'h3F80, 16'h3F80, 1'b1)),
            64'(mk(1'b0, 8'h0, 11'h0, 11'h0, 1'b1, 1'b1, 16'h0000)));
        chk("pin_negzero", 64'(model(16'h8000, 16'h8000, 1'b0)),
            64'(mk(1'b0, 8'h0, 11'h0, 11'h0, 1'b0, 1'b1, 16'h8000)));
        chk("pin_nan", 64'(model(16'h7FC1, 16'h3F80, 1'b0)),
            64'(mk(1'b0, 8'h0, 11'h0, 11'h0, 1'b0, 1'b1, 16'h7FC0)));
        chk("pin_neginf", 64'(model(16'hFF80, 16'h4000, 1'b0)),
            64'(mk(1'b0, 8'h0, 11'h0, 11'h0, 1'b1, 1'b1, 16'hFF80)));

        // Latency: result visible exactly two edges after acceptance.
        out_ready = 1'b1;
        send(16'h4000, 16'h3F80, 1'b1);
        @(negedge clk);
        chk("latency_1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_2", 64'(out_valid), 64'd1);
        chk("lit_sub", 64'(dut_out()),
            64'(mk(1'b0, 8'h80, 11'h400, 11'h200, 1'b1, 1'b0, 16'h0)));

        send(16'h3F80, 16'hC040, 1'b0);
        send(16'h4B00, 16'h3F81, 1'b0);
        send(16'h7F80, 16'h7F80, 1'b1);
        send(16'h3F80, 16'h3F80, 1'b1);
        send(16'h8000, 16'h8000, 1'b0);
        send(16'h7FC1, 16'h3F80, 1'b0);
        send(16'hFF80, 16'h4000, 1'b0);
        repeat (4) @(negedge clk);

        // Backpressure: three ops against a stalled output.
        bp_a = '{16'h4040, 16'hC0A0, 16'h3E00};
        bp_b = '{16'h3F00, 16'h4100, 16'hBE80};
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (acc < 3) begin
                a = bp_a[acc]; b = bp_b[acc]; op = 1'(i); in_valid = 1'b1;
            end
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took) acc++;
        end
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took) begin
                acc++;
                in_valid = 1'b0;
            end
        end
        chk("bp_consecutive", 64'(cnt), 64'd3);
        chk("bp_all_in", 64'(acc), 64'd3);
        repeat (3) @(negedge clk);

        // Reset with two ops in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h4000, 16'h3F80, 1'b0);
        send(16'h4040, 16'h4000, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_data", 64'(dut_out()), 64'd0);
        chk("rst_mid_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rst_flushed", 64'(cnt), 64'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took || !in_valid) begin
                in_valid = ($urandom % 4) != 0;
                a = rnd_op(16'($urandom));
                b = rnd_op(a);
                op = 1'($urandom);
            end
            out_ready = ($urandom % 4) != 0;
        end
        @(negedge clk);
        took = in_valid && in_ready;
        @(posedge clk); #1;
        if (!took) begin
            out_ready = 1'b1;
            n = 0;
            while (!(in_valid && in_ready) && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
